// File: rtl/minirisc_div_pkg.sv
// minirisc_div_pkg: FSM state encoding and sizing helper for the restoring divider.
package minirisc_div_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction
endpackage

// File: rtl/cla_subtractor.sv
// cla_subtractor: N-bit a-b computed as a+~b+1 on 4-bit carry-lookahead groups; borrow is the inverted carry out.
module cla_subtractor #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);
  localparam int G = N / 4 + 1;
  logic [N:0] p, g, s;
  logic [G-1:0] c;
  logic ci;
  assign p = {1'b0, a} ^ {1'b0, ~b};
  assign g = {1'b0, a} & {1'b0, ~b};
  always_comb begin
    c = '0;
    c[0] = 1'b1;
    for (int k = 0; k < G - 1; k++)
      c[k+1] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (&p[4*k+2 +: 2] & g[4*k+1]) |
               (&p[4*k+1 +: 3] & g[4*k]) | (&p[4*k +: 4] & c[k]);
    s = '0;
    ci = 1'b0;
    for (int i = 0; i <= N; i++) begin
      ci = (i % 4 == 0) ? c[i/4] : ci;
      s[i] = p[i] ^ ci;
      ci = g[i] | (p[i] & ci);
    end
  end
  assign diff   = s[N-1:0];
  assign borrow = ~s[N];
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: multi-cycle restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define SIGNED_DIV_EN to add the is_signed input and a sign fixup cycle after the magnitude divide.
module restoring_divider
  import minirisc_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);
  localparam int CW = cnt_w(WIDTH);
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_mag, b_mag;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dbz_q, dbz_d, dz, last, borrow, keep;
  logic [WIDTH:0] diff;
`ifdef SIGNED_DIV_EN
  logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, sa, sb;
  assign sa    = is_signed & dividend[WIDTH-1];
  assign sb    = is_signed & divisor[WIDTH-1];
  assign a_mag = sa ? -dividend : dividend;
  assign b_mag = sb ? -divisor : divisor;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
`endif
  cla_subtractor #(.N(WIDTH + 1)) u_sub (
    .a      ({rem_q, quo_q[WIDTH-1]}),
    .b      ({1'b0, dvs_q}),
    .diff   (diff),
    .borrow (borrow)
  );
  // keep the shifted remainder when the trial goes negative or would not fit back into rem
  assign keep = borrow | diff[WIDTH];
  assign dz   = divisor == '0;
  assign last = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      S_IDLE: if (in_valid) begin
        dvs_d   = b_mag;
        cnt_d   = '0;
        dbz_d   = dz;
        rem_d   = dz ? dividend : '0;
        quo_d   = dz ? '1 : a_mag;
        state_d = dz ? S_DONE : S_RUN;
`ifdef SIGNED_DIV_EN
        neg_quo_d = sa ^ sb;
        neg_rem_d = sa;
`endif
      end
      S_RUN: begin
        rem_d = keep ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~keep};
        cnt_d = cnt_q + 1'b1;
`ifdef SIGNED_DIV_EN
        state_d = last ? S_FIXUP : S_RUN;
`else
        state_d = last ? S_DONE : S_RUN;
`endif
      end
`ifdef SIGNED_DIV_EN
      S_FIXUP: begin
        quo_d   = neg_quo_q ? -quo_q : quo_q;
        rem_d   = neg_rem_q ? -rem_q : rem_q;
        state_d = S_DONE;
      end
`endif
      default: state_d = out_ready ? S_IDLE : state_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end
  assign in_ready    = state_q == S_IDLE;
  assign out_valid   = state_q == S_DONE;
  assign busy        = state_q != S_IDLE;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed vectors with hand-computed results, latency and handshake checks.
module tb_restoring_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, is_s = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic in_ready, out_valid, div_by_zero, busy;
  logic [31:0] quotient, remainder;
  int n_chk = 0, n_pass = 0;
`ifdef SIGNED_DIV_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  always #5 clk = ~clk;

  restoring_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef SIGNED_DIV_EN
    .is_signed   (is_s),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".in_ready"}, in_ready, 1);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".busy"}, busy, 0);
  endtask

  // lat = clock edges after the accept edge until out_valid is seen
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [31:0] eq, input logic [31:0] er, input logic ed,
                         input int elat, input int hold);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    is_s     = sgn;
    @(posedge clk);
    #1;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'd3;
    is_s     = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, ".lat"}, lat, elat);
    check({tag, ".q"}, quotient, eq);
    check({tag, ".r"}, remainder, er);
    check({tag, ".dbz"}, div_by_zero, ed);
    check({tag, ".busy"}, busy, 1);
    check({tag, ".in_ready"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_q"}, quotient, eq);
      check({tag, ".hold_r"}, remainder, er);
      check({tag, ".hold_valid"}, out_valid, 1);
      check({tag, ".hold_in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_idle({tag, ".handoff"});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");
    check("reset.q", quotient, 0);
    check("reset.r", remainder, 0);
    check("reset.dbz", div_by_zero, 0);

    run_div("100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 32 + XL, 0);
    run_div("5/0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0, 0);
    run_div("3/10", 32'd3, 32'd10, 1'b0, 32'd0, 32'd3, 1'b0, 32 + XL, 0);
    run_div("max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 32 + XL, 0);
    run_div("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0, 32 + XL, 0);
    run_div("2^31/3", 32'h8000_0000, 32'd3, 1'b0, 32'd715827882, 32'd2, 1'b0, 32 + XL, 0);
    run_div("50/6", 32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 1'b0, 32 + XL, 5);

    @(negedge clk);
    in_valid = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrun.busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("midrun_rst");
    check("midrun_rst.q", quotient, 0);
    check("midrun_rst.r", remainder, 0);
    check("midrun_rst.dbz", div_by_zero, 0);
    run_div("9/4", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0, 32 + XL, 0);

`ifdef SIGNED_DIV_EN
    run_div("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 0);
    run_div("s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, 0);
    run_div("smin/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33, 0);
    run_div("s-7/0", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 0, 0);
    run_div("u-7/2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 33, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
